stripe_32to2x8: RTL

- Upstream feeder for the lane-demux level-1 stage.
- Accepts 32-bit words, or 16-bit words in half mode, from the word-level source through a valid/ready handshake.
- Serialises each word onto two 8-bit lanes with per-lane valids over one or two cycles.
- Generates the shared selector that steers each half to the correct demux output pair downstream.

---
 rtl/stripe_32to2x8.sv | 94 +++++++++
 1 files changed

// File: rtl/stripe_32to2x8.sv
// Word-to-lane striper: serialises 32-bit (or 16-bit in half mode) words onto two
// byte lanes, low half first, with a shared half selector for the downstream demux.
module stripe_32to2x8 #(
    parameter int LANE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*LANE_W-1:0] dataIn,
    input  logic                validIn,
    input  logic                mode16,
    output logic                readyOut,
    output logic [LANE_W-1:0]   dataOut0,
    output logic [LANE_W-1:0]   dataOut1,
    output logic                validOut0,
    output logic                validOut1,
    output logic                selector,
    output logic [7:0]          wordCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LO_PEND = 2'd1,
        LAST    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2*LANE_W-1:0] hold;
    logic [2*LANE_W-1:0] hold_next;
    logic [LANE_W-1:0]   data0_next;
    logic [LANE_W-1:0]   data1_next;
    logic                valid_q;
    logic                valid_next;
    logic                sel_next;
    logic [7:0]          count_next;
    logic                accept;

    // Only the cycle that shows a low half with its high half still held refuses input,
    // so 32-bit words stream at one per two cycles and half-mode words at one per cycle.
    assign readyOut = (state != LO_PEND);
    assign accept   = validIn & readyOut;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_next = IDLE;
        hold_next  = hold;
        data0_next = '0;
        data1_next = '0;
        valid_next = 1'b0;
        sel_next   = 1'b0;
        count_next = wordCount;

        if (accept) begin
            data0_next = dataIn[LANE_W-1:0];
            data1_next = dataIn[2*LANE_W-1:LANE_W];
            valid_next = 1'b1;
            hold_next  = dataIn[4*LANE_W-1:2*LANE_W];
            count_next = wordCount + 8'd1;
            state_next = mode16 ? LAST : LO_PEND;
        end else if (state == LO_PEND) begin
            data0_next = hold[LANE_W-1:0];
            data1_next = hold[2*LANE_W-1:LANE_W];
            valid_next = 1'b1;
            sel_next   = 1'b1;
            state_next = LAST;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hold      <= '0;
            dataOut0  <= '0;
            dataOut1  <= '0;
            valid_q   <= 1'b0;
            selector  <= 1'b0;
            wordCount <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= state_next;
            hold      <= hold_next;
            dataOut0  <= data0_next;
            dataOut1  <= data1_next;
            valid_q   <= valid_next;
            selector  <= sel_next;
            wordCount <= count_next;
        end
    end

    // Both lanes always carry the same half, so one register drives both valids.
    assign validOut0 = valid_q;
    assign validOut1 = valid_q;

endmodule
